// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: issues one request at a time to a variable-latency
// instruction memory, buffers returned instructions and drives PC hold/advance.
//
// state  | meaning
// S_IDLE | no request outstanding; issue at pc_val when buffer has room
// S_WAIT | request outstanding; response is pushed into the buffer
// S_DROP | request outstanding after a redirect; response is discarded
module inst_fetch_unit #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_val,
   input  logic              flush,
   output logic              hold_pc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic              id_stall,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t            state;
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W:0]    count;
   logic              push;
   logic              pop;

   // The PC steps only on an accepted fetch or a redirect.
   assign hold_pc     = !(flush || (state == S_WAIT && mem_ready));
   assign push        = (state == S_WAIT) && mem_ready && !flush;
   assign pop         = instr_valid && !id_stall && !flush;
   assign instr_valid = (count != '0);
   assign instr       = data_mem[rd_ptr];
   assign instr_pc    = pc_mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!flush && count < CNT_FULL) begin
                  mem_addr <= pc_val;
                  mem_req  <= 1'b1;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  state   <= S_IDLE;
               end else if (flush) begin
                  state <= S_DROP;
               end
            end
            S_DROP: begin
               // The memory cannot take a request back; wait it out.
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
            pc_mem[i]   <= '0;
         end
      end else if (push) begin
         data_mem[wr_ptr] <= mem_rdata;
         pc_mem[wr_ptr]   <= mem_addr;
      end
   end

endmodule
